// File: rtl/fpu_add_sub_aligner_if.sv
// Handshake and data bundle for the FPU add/sub operand aligner.
// Master drives operands and result-ready; slave is the aligner.
interface fpu_add_sub_aligner_if;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        op_sub_i;
    logic        valid_o;
    logic        ready_i;
    logic [26:0] mant_large_o;
    logic [26:0] mant_small_o;
    logic [7:0]  exp_o;
    logic        sign_o;
    logic        eff_sub_o;
    logic        sticky_only_o;

    modport master (
        output valid_i, op_a_i, op_b_i, op_sub_i, ready_i,
        input  ready_o, valid_o, mant_large_o, mant_small_o,
        input  exp_o, sign_o, eff_sub_o, sticky_only_o
    );

    modport slave (
        input  valid_i, op_a_i, op_b_i, op_sub_i, ready_i,
        output ready_o, valid_o, mant_large_o, mant_small_o,
        output exp_o, sign_o, eff_sub_o, sticky_only_o
    );
endinterface

// File: rtl/fpu_add_sub_aligner.sv
// Multi-cycle add/sub operand aligner: orders operands by magnitude and
// shifts the smaller significand right STEP bits per cycle with sticky.
// Optional feature macro: FPU_ALIGN_FASTPATH_EN (1-cycle saturated shifts).
module fpu_add_sub_aligner #(
    parameter int STEP = 4
) (
    input logic clk_i,
    input logic reset_i,
    fpu_add_sub_aligner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [4:0] STEP_W = 5'(STEP);

    state_t      state_q, state_d;
    logic [26:0] mant_large_q, mant_small_q;
    logic [7:0]  exp_q;
    logic        sign_q, eff_sub_q;
    logic [4:0]  rem_q;

    logic        sign_b, b_big;
    logic [31:0] lg;
    logic [30:0] sm;
    logic [7:0]  exp_l, exp_s, diff;
    logic [26:0] mant_l, mant_s, mant_s_load;
    logic [4:0]  shamt, rem_load, step_amt;
    logic [26:0] lost_mask, mant_sh;
    logic        accept;

    // Order operands by magnitude and compute the saturated shift amount.
    always_comb begin
        sign_b = bus.op_b_i[31] ^ bus.op_sub_i;
        b_big  = bus.op_b_i[30:0] > bus.op_a_i[30:0];
        lg     = b_big ? {sign_b, bus.op_b_i[30:0]} : bus.op_a_i;
        sm     = b_big ? bus.op_a_i[30:0] : bus.op_b_i[30:0];
        exp_l  = (lg[30:23] == 8'd0) ? 8'd1 : lg[30:23];
        exp_s  = (sm[30:23] == 8'd0) ? 8'd1 : sm[30:23];
        diff   = exp_l - exp_s;
        mant_l = {|lg[30:23], lg[22:0], 3'b000};
        mant_s = {|sm[30:23], sm[22:0], 3'b000};
        shamt  = (diff > 8'd27) ? 5'd27 : diff[4:0];
`ifdef FPU_ALIGN_FASTPATH_EN
        if (diff >= 8'd27) begin
            mant_s_load = {26'd0, |mant_s};
            rem_load    = 5'd0;
        end else begin
            mant_s_load = mant_s;
            rem_load    = shamt;
        end
`else
        mant_s_load = mant_s;
        rem_load    = shamt;
`endif
    end

    // One shift step: move right and fold every dropped bit into bit 0.
    always_comb begin
        step_amt  = (rem_q < STEP_W) ? rem_q : STEP_W;
        lost_mask = (27'd1 << step_amt) - 27'd1;
        mant_sh   = (mant_small_q >> step_amt)
                  | {26'd0, |(mant_small_q & lost_mask)};
    end

    assign accept = (state_q == IDLE) && bus.valid_i;

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i)
                    state_d = (rem_load == 5'd0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (rem_q == step_amt) state_d = DONE;
            end
            DONE: begin
                if (bus.ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: load on accept, shift while in SHIFT.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mant_large_q <= '0;
            mant_small_q <= '0;
            exp_q        <= '0;
            sign_q       <= 1'b0;
            eff_sub_q    <= 1'b0;
            rem_q        <= '0;
        end else if (accept) begin
            mant_large_q <= mant_l;
            mant_small_q <= mant_s_load;
            exp_q        <= exp_l;
            sign_q       <= lg[31];
            eff_sub_q    <= bus.op_a_i[31] ^ sign_b;
            rem_q        <= rem_load;
        end else if (state_q == SHIFT) begin
            mant_small_q <= mant_sh;
            rem_q        <= rem_q - step_amt;
        end
    end

    assign bus.ready_o       = (state_q == IDLE);
    assign bus.valid_o       = (state_q == DONE);
    assign bus.mant_large_o  = mant_large_q;
    assign bus.mant_small_o  = mant_small_q;
    assign bus.exp_o         = exp_q;
    assign bus.sign_o        = sign_q;
    assign bus.eff_sub_o     = eff_sub_q;
    assign bus.sticky_only_o = (mant_small_q[26:1] == 26'd0)
                             & mant_small_q[0];
endmodule

// File: doc/fpu_add_sub_aligner.md
# fpu_add_sub_aligner

Multi-cycle operand alignment stage for the FPU add/sub datapath. It runs ahead of the add/sub rounder and produces the aligned significands, the guard/round/sticky bits, and the sign and operand-size flags that the rounder consumes. It orders two IEEE-754 single-precision operands by magnitude and right-shifts the smaller significand by the exponent difference, a few bits per cycle, folding shifted-out bits into sticky. Input and output use valid/ready handshakes.

## Interface
- STEP, 4: maximum right-shift bits per SHIFT cycle; legal values 1, 2, 4, 8.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  operands valid.
- ready_o  out  1  block idle and able to accept operands.
- op_a_i  in  32  operand A, IEEE-754 single.
- op_b_i  in  32  operand B, IEEE-754 single.
- op_sub_i  in  1  1 = A−B; B's sign is inverted before processing.
- valid_o  out  1  aligned result valid.
- ready_i  in  1  downstream accepts the result.
- mant_large_o  out  27  {hidden, frac[22:0], 3'b000} of the larger operand.
- mant_small_o  out  27  smaller operand significand after alignment; bits [2:0] = G,R,S.
- exp_o  out  8  effective exponent of the larger operand.
- sign_o  out  1  sign of the larger operand, using B's effective sign.
- eff_sub_o  out  1  sign_a XOR effective sign_b; drives the rounder's sign_less.
- sticky_only_o  out  1  mant_small_o[26:1]==0 and mant_small_o[0]==1; drives the rounder's second_operand_zero.

## Operation
- Hidden bit = (exp != 0). Effective exponent = exp, or 1 when exp == 0.
- The block does not special-case NaN or Inf. Those operands are processed arithmetically, and the downstream special-case logic overrides the result.
- Magnitude order: compare bits [30:0]. B is the larger operand only if B[30:0] > A[30:0]; on a tie, A is the larger.
- d = eff_exp_large − eff_exp_small. The shift amount saturates at 27.
- Sticky: at every step, OR all bits shifted past bit 0 (including the old bit 0) into bit 0.
- States:
  - IDLE: ready_o=1. On valid_i && ready_o, register the ordered operands, exp_o, sign_o, eff_sub_o and the remaining shift amount. Go to SHIFT if remaining > 0, else go to DONE.
  - SHIFT: shift mant_small right by min(STEP, remaining) with sticky folding, and subtract that amount from remaining. Go to DONE when remaining reaches 0.
  - DONE: valid_o=1 and all outputs held stable. On ready_i, go to IDLE.
- ready_o is 0 in SHIFT and DONE. valid_i is ignored there, with no queuing.
- sticky_only_o is derived combinationally from the registered mant_small_o.

## Timing
- Reset: state=IDLE, ready_o=1, valid_o=0, all data outputs 0.
- Reset asserted mid-SHIFT or mid-DONE aborts immediately. No partial result is ever presented.
- Latency from the accept edge to valid_o high = 1 + ceil(min(d,27)/STEP) cycles.
  - d=0 gives 1 cycle.
  - The fast path (see Configuration) gives 1 cycle for d≥27.
- Throughput: one operation in flight at a time.
  - In DONE with ready_i=1, the block returns to IDLE on that edge.
  - ready_o rises the cycle after the result is accepted.
  - The minimum issue interval is latency+1 cycles.
- Backpressure: with ready_i=0, the block stays in DONE indefinitely and outputs must not change.

## Configuration
- FPU_ALIGN_FASTPATH_EN defined:
  - When the accepted d ≥ 27, the load cycle writes mant_small = 27'h1 if the smaller significand is nonzero (else 0), and goes straight to DONE.
  - Latency is 1 cycle.
- FPU_ALIGN_FASTPATH_EN undefined:
  - Saturated shifts iterate through SHIFT for ceil(27/STEP) cycles.
  - Final outputs are bit-identical to the fast path; only latency differs.

## Test plan
- STEP=1, A=0x3F800000, B=0x3F800000, op_sub=0 -> valid_o 1 cycle after accept; mant_large=mant_small=0x4000000, exp_o=0x7F, eff_sub=0, G,R,S=000, sticky_only=0.
- STEP=1, A=0x3F800000, B=0x3F000001 -> valid_o after 2 cycles; mant_small=0x2000004, G,R,S=100.
- STEP=4, A=0x4B800000, B=0x3F800001 (d=24) -> valid_o after 7 cycles; mant_small=0x0000005, exp_o=0x97, sticky_only=0.
- STEP=1, A=0x4F800000, B=0x3F800000 (d=32) -> mant_small=0x0000001, sticky_only=1; valid_o after 28 cycles without FPU_ALIGN_FASTPATH_EN, after 1 cycle with it.
- A=0x3F800000, B=0x40000000, op_sub=1 -> swap: exp_o=0x80, sign_o=1, eff_sub=1, mant_large=0x4000000, mant_small=0x2000000.
- Backpressure and reset:
  - Hold ready_i=0 for 10 cycles in DONE -> outputs stable, ready_o=0, a valid_i pulse is ignored.
  - Drop reset_i mid-SHIFT -> valid_o=0 and ready_o=1 without waiting for a clock edge.
